midi_byte_parser: RTL and testbench



---
 rtl/midi_pkg.sv | 49 ++++
 rtl/midi_byte_parser.sv | 157 +++++++++++++++
 tb/tb_midi_byte_parser.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : midi_pkg
//  Description : Shared MIDI byte-class constants, parser state encoding,
//                byte classifier and channel-message length helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package midi_pkg;

   localparam logic [7:0] MIDI_RT_MIN      = 8'hF8;
   localparam logic [7:0] MIDI_SYSEX_START = 8'hF0;
   localparam logic [7:0] MIDI_SYSEX_END   = 8'hF7;
   localparam logic [7:0] MIDI_STATUS_NONE = 8'h00;

   // IDLE : no running status, data bytes are dropped and counted
   // CHAN : running status valid, data bytes are forwarded
   // SYSEX: inside a System Exclusive dump, data bytes are swallowed silently
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHAN  = 2'd1,
      SYSEX = 2'd2
   } parser_state_t;

   typedef enum logic [2:0] {
      BC_DATA        = 3'd0,
      BC_CHAN        = 3'd1,
      BC_SYSEX_START = 3'd2,
      BC_SYSEX_END   = 3'd3,
      BC_SYS_COMMON  = 3'd4,
      BC_REALTIME    = 3'd5
   } byte_class_t;

   // Number of data bytes carried by a channel message: program change and
   // channel pressure (C0-DF) carry one, every other channel message two.
   function automatic logic [7:0] msg_len(input logic [7:0] status);
      return ((status >= 8'hC0) && (status <= 8'hDF)) ? 8'd1 : 8'd2;
   endfunction

   function automatic byte_class_t classify_byte(input logic [7:0] b);
      if (b >= MIDI_RT_MIN)           return BC_REALTIME;
      else if (b == MIDI_SYSEX_START) return BC_SYSEX_START;
      else if (b == MIDI_SYSEX_END)   return BC_SYSEX_END;
      else if (b > MIDI_SYSEX_START)  return BC_SYS_COMMON;
      else if (b[7])                  return BC_CHAN;
      else                            return BC_DATA;
   endfunction

endpackage
`default_nettype wire

// File: rtl/midi_byte_parser.sv
`default_nettype none
// ============================================================================
//  Module      : midi_byte_parser
//  Description : Converts a raw MIDI byte stream into the parsed tuple used
//                by the MIDI input mux (byteready / cur_status / midibyte_nr /
//                midi_in_data). Tracks running status, suppresses SysEx,
//                extracts real-time bytes and counts discarded bytes.
//  Revision    : 1.0 - initial release
//
//  Ports
//    reg_clk      in   1      system clock
//    reset_reg_N  in   1      synchronous reset, active low
//    rx_valid     in   1      strobe, raw byte present on rx_byte
//    rx_byte      in   8      raw MIDI byte
//    byteready    out  1      pulse, parsed byte valid
//    cur_status   out  8      current running status (00 = none)
//    midibyte_nr  out  8      0 = status byte, 1/2 = data byte index
//    midi_in_data out  8      byte just accepted
//    rt_valid     out  1      pulse, real-time byte on rt_byte
//    rt_byte      out  8      last real-time byte
//    drop_cnt     out  CNT_W  saturating count of discarded bytes
// ============================================================================
module midi_byte_parser #(
   parameter int CNT_W = 8
) (
   input  logic             reg_clk,
   input  logic             reset_reg_N,
   input  logic             rx_valid,
   input  logic [7:0]       rx_byte,
   output logic             byteready,
   output logic [7:0]       cur_status,
   output logic [7:0]       midibyte_nr,
   output logic [7:0]       midi_in_data,
   output logic             rt_valid,
   output logic [7:0]       rt_byte,
   output logic [CNT_W-1:0] drop_cnt
);
   import midi_pkg::*;

   localparam logic [CNT_W-1:0] DROP_MAX = '1;

   parser_state_t    state_q, state_d;
   logic [7:0]       cur_status_q, cur_status_d;
   logic [7:0]       midibyte_nr_q, midibyte_nr_d;
   logic [7:0]       midi_in_data_q, midi_in_data_d;
   logic             byteready_q, byteready_d;
   logic             rt_valid_q, rt_valid_d;
   logic [7:0]       rt_byte_q, rt_byte_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             drop_inc;
   byte_class_t      byte_class;

   assign byte_class = classify_byte(rx_byte);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge reg_clk) begin
      if (!reset_reg_N) state_q <= IDLE;
      else              state_q <= state_d;
   end

   // ---------------------------------------------------------- next-state comb
   // Real-time and data bytes never move the FSM.
   always_comb begin
      state_d = state_q;
      if (rx_valid) begin
         case (byte_class)
            BC_CHAN:        state_d = CHAN;
            BC_SYSEX_START: state_d = SYSEX;
            BC_SYSEX_END,
            BC_SYS_COMMON:  state_d = IDLE;
            default:        state_d = state_q;
         endcase
      end
   end

   // -------------------------------------------------------------- output comb
   always_comb begin
      cur_status_d   = cur_status_q;
      midibyte_nr_d  = midibyte_nr_q;
      midi_in_data_d = midi_in_data_q;
      rt_byte_d      = rt_byte_q;
      byteready_d    = 1'b0;
      rt_valid_d     = 1'b0;
      drop_inc       = 1'b0;
      if (rx_valid) begin
         case (byte_class)
            BC_REALTIME: begin
               rt_valid_d = 1'b1;
               rt_byte_d  = rx_byte;
            end
            BC_CHAN: begin
               cur_status_d   = rx_byte;
               midibyte_nr_d  = 8'd0;
               midi_in_data_d = rx_byte;
               byteready_d    = 1'b1;
            end
            BC_SYSEX_START: cur_status_d = MIDI_STATUS_NONE;
            BC_SYSEX_END: begin
               cur_status_d = MIDI_STATUS_NONE;
               drop_inc     = (state_q != SYSEX);   // stray end-of-exclusive
            end
            BC_SYS_COMMON: begin
               cur_status_d = MIDI_STATUS_NONE;
               drop_inc     = 1'b1;
            end
            default: begin   // data byte
               if (state_q == CHAN) begin
                  byteready_d    = 1'b1;
                  midi_in_data_d = rx_byte;
                  // Once the message is complete the next data byte starts a
                  // new message under running status.
                  if (midibyte_nr_q < msg_len(cur_status_q))
                     midibyte_nr_d = midibyte_nr_q + 8'd1;
                  else
                     midibyte_nr_d = 8'd1;
               end else if (state_q == IDLE) begin
                  drop_inc = 1'b1;
               end
            end
         endcase
      end
      drop_cnt_d = drop_cnt_q;
      if (drop_inc && (drop_cnt_q != DROP_MAX))
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
   end

   // ----------------------------------------------------------- output regs
   always_ff @(posedge reg_clk) begin
      if (!reset_reg_N) begin
         cur_status_q   <= MIDI_STATUS_NONE;
         midibyte_nr_q  <= 8'h00;
         midi_in_data_q <= 8'h00;
         byteready_q    <= 1'b0;
         rt_valid_q     <= 1'b0;
         rt_byte_q      <= 8'h00;
         drop_cnt_q     <= '0;
      end else begin
         cur_status_q   <= cur_status_d;
         midibyte_nr_q  <= midibyte_nr_d;
         midi_in_data_q <= midi_in_data_d;
         byteready_q    <= byteready_d;
         rt_valid_q     <= rt_valid_d;
         rt_byte_q      <= rt_byte_d;
         drop_cnt_q     <= drop_cnt_d;
      end
   end

   assign byteready    = byteready_q;
   assign cur_status   = cur_status_q;
   assign midibyte_nr  = midibyte_nr_q;
   assign midi_in_data = midi_in_data_q;
   assign rt_valid     = rt_valid_q;
   assign rt_byte      = rt_byte_q;
   assign drop_cnt     = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_byte_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_midi_byte_parser
//  Description : Self-checking bench for midi_byte_parser. Directed message
//                sequences, randomized byte streams with occasional resets,
//                and drop counter saturation, all against a message-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_byte_parser;

   localparam int CNT_W = 8;

   logic             reg_clk = 1'b0;
   logic             reset_reg_N;
   logic             rx_valid;
   logic [7:0]       rx_byte;
   logic             byteready;
   logic [7:0]       cur_status;
   logic [7:0]       midibyte_nr;
   logic [7:0]       midi_in_data;
   logic             rt_valid;
   logic [7:0]       rt_byte;
   logic [CNT_W-1:0] drop_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   logic [7:0] m_status;   // running status, 0 = none
   bit         m_sysex;
   int         m_k;        // data bytes seen since the last status byte
   int         m_drop;
   // expected outputs
   logic       e_br, e_rtv;
   logic [7:0] e_nr, e_data, e_rtb;

   always #5 reg_clk = ~reg_clk;

   midi_byte_parser #(.CNT_W(CNT_W)) dut (
      .reg_clk      (reg_clk),
      .reset_reg_N  (reset_reg_N),
      .rx_valid     (rx_valid),
      .rx_byte      (rx_byte),
      .byteready    (byteready),
      .cur_status   (cur_status),
      .midibyte_nr  (midibyte_nr),
      .midi_in_data (midi_in_data),
      .rt_valid     (rt_valid),
      .rt_byte      (rt_byte),
      .drop_cnt     (drop_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string step);
      check({step, "/byteready"},    32'(byteready),    32'(e_br));
      check({step, "/cur_status"},   32'(cur_status),   32'(m_status));
      check({step, "/midibyte_nr"},  32'(midibyte_nr),  32'(e_nr));
      check({step, "/midi_in_data"}, 32'(midi_in_data), 32'(e_data));
      check({step, "/rt_valid"},     32'(rt_valid),     32'(e_rtv));
      check({step, "/rt_byte"},      32'(rt_byte),      32'(e_rtb));
      check({step, "/drop_cnt"},     32'(drop_cnt),     32'(m_drop));
   endtask

   function automatic void model_reset();
      m_status = 8'h00; m_sysex = 1'b0; m_k = 0; m_drop = 0;
      e_br = 1'b0; e_rtv = 1'b0; e_nr = 8'h00; e_data = 8'h00; e_rtb = 8'h00;
   endfunction

   function automatic void model_drop();
      if (m_drop < (1 << CNT_W) - 1) m_drop++;
   endfunction

   // Message-level view: the n-th data byte after a status byte (n from 0)
   // sits at position (n mod LEN) + 1.
   function automatic void model_byte(input logic [7:0] b);
      int len;
      e_br  = 1'b0;
      e_rtv = 1'b0;
      if (b >= 8'hF8) begin
         e_rtv = 1'b1;
         e_rtb = b;
      end else if (b >= 8'h80 && b <= 8'hEF) begin
         m_status = b; m_sysex = 1'b0; m_k = 0;
         e_br = 1'b1; e_nr = 8'd0; e_data = b;
      end else if (b == 8'hF0) begin
         m_sysex = 1'b1; m_status = 8'h00;
      end else if (b == 8'hF7) begin
         if (!m_sysex) model_drop();
         m_sysex = 1'b0; m_status = 8'h00;
      end else if (b > 8'hF0) begin
         m_sysex = 1'b0; m_status = 8'h00;
         model_drop();
      end else if (m_sysex) begin
         // swallowed inside SysEx, not counted
      end else if (m_status == 8'h00) begin
         model_drop();
      end else begin
         len    = (m_status >= 8'hC0 && m_status <= 8'hDF) ? 1 : 2;
         e_br   = 1'b1;
         e_data = b;
         e_nr   = 8'((m_k % len) + 1);
         m_k++;
      end
   endfunction

   task automatic send(input logic [7:0] b, input string step);
      @(negedge reg_clk);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(posedge reg_clk);
      #1;
      rx_valid = 1'b0;
      model_byte(b);
      check_all(step);
   endtask

   task automatic idle(input string step);
      @(negedge reg_clk);
      rx_valid = 1'b0;
      rx_byte  = 8'($urandom);
      @(posedge reg_clk);
      #1;
      e_br  = 1'b0;
      e_rtv = 1'b0;
      check_all(step);
   endtask

   task automatic do_reset(input string step);
      @(negedge reg_clk);
      reset_reg_N = 1'b0;
      rx_valid    = 1'b0;
      @(posedge reg_clk);
      #1;
      reset_reg_N = 1'b1;
      model_reset();
      check_all(step);
   endtask

   task automatic send_seq(input logic [7:0] seq[$], input string name);
      foreach (seq[i]) send(seq[i], $sformatf("%s[%0d]", name, i));
   endtask

   logic [7:0] rb;
   int         sel;

   initial begin
      reset_reg_N = 1'b0;
      rx_valid    = 1'b0;
      rx_byte     = 8'h00;
      model_reset();
      repeat (2) @(posedge reg_clk);
      do_reset("reset");

      send_seq('{8'h90, 8'h3C, 8'h64}, "note_on");
      send_seq('{8'h3E, 8'h50}, "running");
      idle("idle1");
      send_seq('{8'hC5, 8'h07, 8'h09}, "prog_chg");
      send_seq('{8'h90, 8'h3C, 8'hF8, 8'h64}, "rt_mid");
      send_seq('{8'hF0, 8'h7E, 8'hFE, 8'h01, 8'hF7, 8'h22}, "sysex");
      send_seq('{8'hF7, 8'hF3, 8'h10}, "stray");
      send_seq('{8'hB0, 8'h07, 8'h7F, 8'h0A, 8'hE2, 8'h00, 8'h40}, "ctl_bend");
      send_seq('{8'hD1, 8'h33, 8'hF0, 8'hC1, 8'h05, 8'h06}, "sysex_abort");

      // reset between a status byte and its data byte
      do_reset("pre_mid");
      send(8'h90, "mid_reset_status");
      do_reset("mid_reset");
      send_seq('{8'h3C, 8'h80, 8'h40, 8'h00}, "post_reset");

      // randomized stream, back-to-back and with gaps
      for (int i = 0; i < 800; i++) begin
         sel = int'($urandom_range(0, 99));
         if (sel < 50)      rb = 8'($urandom_range(8'h00, 8'h7F));
         else if (sel < 70) rb = 8'($urandom_range(8'h80, 8'hEF));
         else if (sel < 76) rb = 8'hF0;
         else if (sel < 82) rb = 8'hF7;
         else if (sel < 87) rb = 8'($urandom_range(8'hF1, 8'hF6));
         else               rb = 8'($urandom_range(8'hF8, 8'hFF));
         if (sel == 0 && ($urandom_range(0, 3) == 0)) do_reset($sformatf("rnd_rst%0d", i));
         else if (sel == 1) idle($sformatf("rnd_idle%0d", i));
         send(rb, $sformatf("rnd%0d", i));
      end

      // drop counter saturation
      do_reset("pre_sat");
      for (int i = 0; i < 260; i++) send(8'($urandom_range(0, 127)), $sformatf("sat%0d", i));
      send(8'hF5, "sat_common");
      send_seq('{8'h85, 8'h11}, "sat_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
